// File: rtl/winograd_pkg.sv
// Shared widths, geometry and FSM encoding for the Winograd feature-buffer readers.
package winograd_pkg;

  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 10;
  localparam int DEPTH      = 960;
  localparam int LINE_W     = 240;
  localparam int TILE_N     = 4;
  localparam int TILE_WORDS = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  // Circular add; both operands stay below DEPTH, so one conditional subtract is enough.
  function automatic logic [ADDR_W-1:0] wrap_add(input logic [ADDR_W-1:0] a,
                                                 input logic [ADDR_W-1:0] b);
    logic [ADDR_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= (ADDR_W+1)'(DEPTH))
      return ADDR_W'(sum - (ADDR_W+1)'(DEPTH));
    else
      return sum[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/winograd_tile_reader_if.sv
// Command, buffer read port and tile stream of the tile reader bundled as one interface.
interface winograd_tile_reader_if;
  import winograd_pkg::*;

  logic              io_start;
  logic [ADDR_W-1:0] io_base_addr;
  logic              io_busy;
  logic              io_done;
  logic [ADDR_W-1:0] io_rd_addr;
  logic              io_rd_en;
  logic [DATA_W-1:0] io_rd_data;
  logic [DATA_W-1:0] io_out_data;
  logic              io_out_valid;
  logic              io_out_ready;
  logic              io_out_last;

  modport slave (
    input  io_start, io_base_addr, io_rd_data, io_out_ready,
    output io_busy, io_done, io_rd_addr, io_rd_en, io_out_data, io_out_valid, io_out_last
  );

  modport master (
    output io_start, io_base_addr, io_rd_data, io_out_ready,
    input  io_busy, io_done, io_rd_addr, io_rd_en, io_out_data, io_out_valid, io_out_last
  );

endinterface

// File: rtl/winograd_tile_reader_fifo2.sv
// Two-entry valid/ready FIFO with occupancy, shared by the feature-buffer readers.
module tile_out_fifo2 #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  output logic [1:0]   occ
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  // A push while full is only taken if the head leaves in the same cycle.
  assign do_push   = push && ((occ != 2'd2) || do_pop);
  assign do_pop    = pop && out_valid;
  assign out_valid = (occ != 2'd0);
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop)
        rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/winograd_tile_reader.sv
// Fetches one 4x4 tile from the circular feature buffer and streams it row-major
// to the Winograd input transform at one word per cycle under backpressure.
module winograd_tile_reader
  import winograd_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  winograd_tile_reader_if.slave  io
);

  state_t            state, state_next;
  logic [ADDR_W-1:0] row_base;
  logic [3:0]        r;
  logic [3:0]        k;
  logic              inflight;
  logic              done_q;
  logic              issue;
  logic              pop;
  logic              last_pop;
  logic [1:0]        occ;
  logic              out_valid;
  logic [2:0]        pending;
  logic [2:0]        limit;

  assign pop      = out_valid && io.io_out_ready;
  assign last_pop = pop && (k == 4'(TILE_WORDS-1));

  // Reads already owed to the FIFO, minus the word leaving now, must leave a free slot.
  assign pending = {1'b0, occ} + {2'b0, inflight};
  assign limit   = 3'd2 + {2'b0, pop};

  tile_out_fifo2 #(.W(DATA_W)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (inflight),
    .push_data (io.io_rd_data),
    .pop       (pop),
    .out_data  (io.io_out_data),
    .out_valid (out_valid),
    .occ       (occ)
  );

  assign io.io_out_valid = out_valid;
  assign io.io_out_last  = out_valid && (k == 4'(TILE_WORDS-1));
  assign io.io_rd_en     = issue;
  assign io.io_rd_addr   = wrap_add(row_base, ADDR_W'(r[1:0]));
  assign io.io_busy      = (state != IDLE);
  assign io.io_done      = done_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (io.io_start)
          state_next = ISSUE;
      end
      ISSUE: begin
        issue = (pending < limit);
        if (issue && (r == 4'(TILE_WORDS-1)))
          state_next = DRAIN;
      end
      DRAIN: begin
        if (last_pop)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Row base advances by one buffered line after the last column of each tile row.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      row_base <= '0;
      r        <= '0;
      k        <= '0;
      inflight <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      inflight <= issue;
      done_q   <= (state == DRAIN) && last_pop;
      if (pop)
        k <= k + 4'd1;
      if (issue) begin
        r <= r + 4'd1;
        if (r[1:0] == 2'(TILE_N-1))
          row_base <= wrap_add(row_base, ADDR_W'(LINE_W));
      end
      if ((state == IDLE) && io.io_start) begin
        row_base <= io.io_base_addr;
        r        <= '0;
        k        <= '0;
      end
    end
  end

endmodule

// File: tb/tb_winograd_tile_reader.sv
// Directed bench for winograd_tile_reader: address order, wrap, backpressure,
// start-while-busy and mid-tile reset against a preloaded buffer model.
module tb_winograd_tile_reader;
  import winograd_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;

  winograd_tile_reader_if bus ();

  winograd_tile_reader dut (
    .clock (clock),
    .reset (reset),
    .io    (bus.slave)
  );

  always #5 clock = ~clock;

  logic [DATA_W-1:0] mem [DEPTH];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc;
  int rd_addr_q[$];
  int rd_cyc_q[$];
  int out_q[$];
  int out_cyc_q[$];
  int done_cnt;
  int done_cyc;
  int m_occ  = 0;
  int m_infl = 0;
  logic stall_prev = 1'b0;
  int   stall_data = 0;
  int bp_pat[40] = '{1,0,0,1,0,1,1,0,0,1, 1,0,0,0,0,0,1,1,0,1,
                     0,0,1,1,1,0,1,0,1,1, 1,1,1,1,1,1,1,1,1,1};

  always @(posedge clock) cyc <= cyc + 1;

  // Buffer read port: one-cycle latency.
  always @(posedge clock)
    if (bus.io_rd_en) bus.io_rd_data <= mem[bus.io_rd_addr];

  task automatic checkOutput(input string tag, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d want %0d", tag, actual, expected);
    end
  endtask

  function automatic int expAddr(input int base, input int i);
    return (base + (i / 4) * LINE_W + (i % 4)) % DEPTH;
  endfunction

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"},  bus.io_busy, 0);
    checkOutput({tag, "_done"},  bus.io_done, 0);
    checkOutput({tag, "_rd_en"}, bus.io_rd_en, 0);
    checkOutput({tag, "_addr"},  bus.io_rd_addr, 0);
    checkOutput({tag, "_valid"}, bus.io_out_valid, 0);
    checkOutput({tag, "_data"},  bus.io_out_data, 0);
    checkOutput({tag, "_last"},  bus.io_out_last, 0);
  endtask

  // Observes every cycle on the falling edge; keeps an independent occupancy model.
  always @(negedge clock) begin
    int pop;
    if (!reset) begin
      m_occ      = 0;
      m_infl     = 0;
      stall_prev = 1'b0;
    end else begin
      pop = (bus.io_out_valid && bus.io_out_ready) ? 1 : 0;
      checkOutput("valid_vs_occ", bus.io_out_valid, (m_occ > 0) ? 1 : 0);
      if (stall_prev) begin
        checkOutput("stall_valid", bus.io_out_valid, 1);
        checkOutput("stall_data", bus.io_out_data, stall_data);
      end
      if (bus.io_rd_en) begin
        checkOutput("issue_rule", (m_occ + m_infl - pop < 2) ? 1 : 0, 1);
        rd_addr_q.push_back(int'(bus.io_rd_addr));
        rd_cyc_q.push_back(cyc);
      end
      if (pop == 1) begin
        checkOutput("last_flag", bus.io_out_last, (out_q.size() == 15) ? 1 : 0);
        out_q.push_back(int'(bus.io_out_data));
        out_cyc_q.push_back(cyc);
      end
      if (bus.io_done) begin
        done_cnt++;
        done_cyc = cyc;
        checkOutput("busy_at_done", bus.io_busy, 0);
      end
      m_occ      = m_occ + m_infl - pop;
      m_infl     = bus.io_rd_en ? 1 : 0;
      stall_prev = bus.io_out_valid && !bus.io_out_ready;
      stall_data = int'(bus.io_out_data);
    end
  end

  // mode 0: ready high, 1: backpressure, 2: start pulse while busy, 3: reset after 7 words
  task automatic applyStimulus(input int base, input int mode);
    int  step;
    bit  injected;
    bit  aborted;
    rd_addr_q.delete();
    rd_cyc_q.delete();
    out_q.delete();
    out_cyc_q.delete();
    done_cnt = 0;
    done_cyc = -1;
    injected = 0;
    aborted  = 0;
    @(posedge clock); #1;
    bus.io_start     = 1'b1;
    bus.io_base_addr = ADDR_W'(base);
    bus.io_out_ready = 1'b1;
    @(posedge clock); #1;
    acc_cyc      = cyc;
    bus.io_start = 1'b0;
    step = 0;
    while (done_cnt == 0 && step < 200 && !aborted) begin
      bus.io_out_ready = (mode == 1 && step < 40) ? bp_pat[step][0] : 1'b1;
      bus.io_start     = 1'b0;
      if (mode == 2 && out_q.size() >= 5 && !injected) begin
        bus.io_start     = 1'b1;
        bus.io_base_addr = ADDR_W'(100);
        injected         = 1;
      end
      if (mode == 3 && out_q.size() >= 7) begin
        reset = 1'b0;
        #1;
        checkIdleOutputs("abort");
        aborted = 1;
      end else begin
        @(posedge clock); #1;
        step++;
      end
    end
    bus.io_start     = 1'b0;
    bus.io_out_ready = 1'b1;
    if (mode == 3) begin
      checkOutput("abort_reached", aborted, 1);
      repeat (3) @(posedge clock);
      #1;
      checkOutput("abort_no_done", done_cnt, 0);
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      checkOutput("abort_no_done_after", done_cnt, 0);
      checkOutput("abort_idle_busy", bus.io_busy, 0);
    end else begin
      checkOutput("tile_timeout", (done_cnt > 0) ? 1 : 0, 1);
      repeat (3) @(posedge clock);
      #1;
      checkOutput("done_once", done_cnt, 1);
      checkOutput("idle_after", bus.io_busy, 0);
    end
  endtask

  task automatic checkTile(input int base, input bit timed);
    int a;
    checkOutput("rd_count", rd_addr_q.size(), 16);
    checkOutput("out_count", out_q.size(), 16);
    for (int i = 0; i < 16; i++) begin
      a = expAddr(base, i);
      if (i < rd_addr_q.size())
        checkOutput($sformatf("rd_addr[%0d]", i), rd_addr_q[i], a);
      if (i < out_q.size())
        checkOutput($sformatf("word[%0d]", i), out_q[i], int'(mem[a]));
      if (timed && i < rd_cyc_q.size() && i < out_cyc_q.size()) begin
        checkOutput($sformatf("rd_cyc[%0d]", i), rd_cyc_q[i] - acc_cyc, i);
        checkOutput($sformatf("out_cyc[%0d]", i), out_cyc_q[i] - acc_cyc, i + 2);
      end
    end
    if (out_cyc_q.size() == 16)
      checkOutput("done_timing", done_cyc - out_cyc_q[15], 1);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++)
      mem[i] = DATA_W'((i * 40503) ^ 23130);
    bus.io_start     = 1'b0;
    bus.io_base_addr = '0;
    bus.io_out_ready = 1'b1;
    bus.io_rd_data   = '0;
    #1;
    checkIdleOutputs("reset");
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;

    applyStimulus(0, 0);
    checkTile(0, 1'b1);
    checkOutput("base0_row1", rd_addr_q[4], 240);
    checkOutput("base0_row3", rd_addr_q[15], 723);

    applyStimulus(955, 0);
    checkTile(955, 1'b1);
    checkOutput("wrap_row0_end", rd_addr_q[3], 958);
    checkOutput("wrap_row1", rd_addr_q[4], 235);
    checkOutput("wrap_row2", rd_addr_q[8], 475);
    checkOutput("wrap_row3", rd_addr_q[12], 715);

    applyStimulus(17, 1);
    checkTile(17, 1'b0);

    applyStimulus(0, 2);
    checkTile(0, 1'b0);
    applyStimulus(100, 0);
    checkTile(100, 1'b1);
    checkOutput("restart_first_addr", rd_addr_q[0], 100);

    applyStimulus(0, 3);
    checkOutput("abort_words", out_q.size(), 7);
    applyStimulus(4, 0);
    checkTile(4, 1'b1);
    checkOutput("after_reset_first", rd_addr_q[0], 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
